// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - write-back arbiter bus bundle with master/slave modports
interface reg_wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        ll_valid;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        ll_ready;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        pend_hit1;
    logic        pend_hit2;
    logic        stallreq;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output ll_valid, ll_waddr, ll_wdata,
        output chk_addr1, chk_addr2,
        input  ll_ready, pend_hit1, pend_hit2, stallreq,
        input  we, waddr, wdata
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  ll_valid, ll_waddr, ll_wdata,
        input  chk_addr1, chk_addr2,
        output ll_ready, pend_hit1, pend_hit2, stallreq,
        output we, waddr, wdata
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register file write-port arbiter: pipeline write-back vs long-latency FIFO
module reg_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    reg_wb_arbiter_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     occ;
    logic [4:0]      q_addr [DEPTH];
    logic [31:0]     q_data [DEPTH];
    logic [DEPTH-1:0] live;
    logic [CW-1:0]   starve_cnt;

    logic            empty;
    logic            full;
    logic            pipe_busy;
    logic            push;
    logic            pop;
    logic            hit1;
    logic            hit2;

    logic            we_q;
    logic [4:0]      waddr_q;
    logic [31:0]     wdata_q;

    assign occ       = wr_ptr - rd_ptr;
    assign empty     = (occ == '0);
    assign full      = (occ == (AW+1)'(DEPTH));
    // A write to $0 does not occupy the port, so the FIFO may use that slot.
    assign pipe_busy = bus.pipe_we && (bus.pipe_waddr != 5'd0);
    assign pop       = !pipe_busy && !empty;
    // Results for $0 complete the handshake but are never stored.
    assign push      = bus.ll_valid && !full && (bus.ll_waddr != 5'd0);

    // FIFO storage; contents are only meaningful inside the live window.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr[AW-1:0]] <= bus.ll_waddr;
            q_data[wr_ptr[AW-1:0]] <= bus.ll_wdata;
        end
    end

    // FIFO pointer update; simultaneous push and pop are independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered write port: pipeline has absolute priority, then FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else if (pipe_busy) begin
            we_q    <= 1'b1;
            waddr_q <= bus.pipe_waddr;
            wdata_q <= bus.pipe_wdata;
        end else if (!empty) begin
            we_q    <= 1'b1;
            waddr_q <= q_addr[rd_ptr[AW-1:0]];
            wdata_q <= q_data[rd_ptr[AW-1:0]];
        end else begin
            we_q    <= 1'b0;
        end
    end

    // Starvation counter: cleared whenever the head moves or nothing waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Mark slots lying between the read pointer and the write pointer.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, AW'(AW'(i) - rd_ptr[AW-1:0])} < occ);
        end
    end

    // Pending-write lookup for ID hazard detection; $0 never hits.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (q_addr[i] == bus.chk_addr1)) begin
                hit1 = 1'b1;
            end
            if (live[i] && (q_addr[i] == bus.chk_addr2)) begin
                hit2 = 1'b1;
            end
        end
    end

    assign bus.ll_ready  = !full;
    assign bus.pend_hit1 = hit1 && (bus.chk_addr1 != 5'd0);
    assign bus.pend_hit2 = hit2 && (bus.chk_addr2 != 5'd0);
    assign bus.stallreq  = (starve_cnt == CW'(STARVE_LIMIT));
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - scoreboard bench for reg_wb_arbiter with queue-based reference model
module tb_reg_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_wb_arbiter_if bus ();

    reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t mq[$];       // reference FIFO contents
    ent_t eq[$];       // expected register-file writes
    int   eq_due[$];   // edge index at which each expected write appears
    int   mstarve = 0;
    int   cyc     = 0;
    bit   armed   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit model_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check combinational outputs, then advance the model on the edge.
    task automatic step();
        int  sz;
        bit  popped;
        #1;
        if (armed) begin
            chk("ll_ready",  32'(bus.ll_ready),  32'(mq.size() < DEPTH));
            chk("pend_hit1", 32'(bus.pend_hit1), 32'(model_hit(bus.chk_addr1)));
            chk("pend_hit2", 32'(bus.pend_hit2), 32'(model_hit(bus.chk_addr2)));
            chk("stallreq",  32'(bus.stallreq),  32'(mstarve == LIMIT));
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mstarve = 0;
            armed   = 1'b1;
        end else if (armed) begin
            sz     = mq.size();
            popped = 1'b0;
            if (bus.pipe_we && bus.pipe_waddr != 5'd0) begin
                eq.push_back({bus.pipe_waddr, bus.pipe_wdata});
                eq_due.push_back(cyc + 1);
            end else if (sz > 0) begin
                eq.push_back(mq.pop_front());
                eq_due.push_back(cyc + 1);
                popped = 1'b1;
            end
            if (sz == 0 || popped) mstarve = 0;
            else if (mstarve < LIMIT) mstarve++;
            if (bus.ll_valid && sz < DEPTH && bus.ll_waddr != 5'd0)
                mq.push_back({bus.ll_waddr, bus.ll_wdata});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld);
        bus.pipe_we    = pwe;
        bus.pipe_waddr = pa;
        bus.pipe_wdata = pd;
        bus.ll_valid   = lv;
        bus.ll_waddr   = la;
        bus.ll_wdata   = ld;
        step();
    endtask

    // Write-port monitor: compares each cycle against the scoreboard queue.
    always @(negedge clk) begin
        ent_t e;
        if (armed) begin
            if (eq.size() > 0 && eq_due[0] <= cyc) begin
                e = eq.pop_front();
                void'(eq_due.pop_front());
                chk("wb_we", 32'(bus.we), 32'd1);
                if (bus.we === 1'b1) begin
                    chk("wb_waddr", 32'(bus.waddr), 32'(e.a));
                    chk("wb_wdata", bus.wdata, e.d);
                end
            end else begin
                chk("wb_idle", 32'(bus.we), 32'd0);
            end
        end
    end

    initial begin
        bus.pipe_we = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
        bus.ll_valid = 1'b0; bus.ll_waddr = '0; bus.ll_wdata = '0;
        bus.chk_addr1 = '0; bus.chk_addr2 = '0;
        @(negedge clk);

        // T1: reset with pipe_we asserted
        rst = 1'b1;
        drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
        drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
        rst = 1'b0;
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_we",    32'(bus.we), 32'd0);

        // T2: single pipeline write
        drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("t2_hold_waddr", 32'(bus.waddr), 32'd5);

        // T3: two long-latency results, hazard lookup on $7/$8
        bus.chk_addr1 = 5'd7; bus.chk_addr2 = 5'd8;
        drive(0, 5'd0, 32'd0, 1, 5'd7, 32'h11);
        drive(0, 5'd0, 32'd0, 1, 5'd8, 32'h22);
        for (int i = 0; i < 3; i++) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // T4: continuous pipeline writes starve a full FIFO
        bus.chk_addr1 = 5'd9; bus.chk_addr2 = 5'd12;
        for (int i = 0; i < 12; i++)
            drive(1, 5'd3, 32'(i), i < 5, 5'(9 + i), 32'(32'h100 + i));
        chk("t4_stallreq", 32'(bus.stallreq), 32'd1);
        chk("t4_ll_ready", 32'(bus.ll_ready), 32'd0);
        for (int i = 0; i < 6; i++) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // T5: $0 traffic is discarded; a queued entry drains in a $0 pipe slot
        drive(1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB);
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        drive(1, 5'd0, 32'hCC, 0, 5'd0, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // T6: reset with entries queued
        bus.chk_addr1 = 5'd10; bus.chk_addr2 = 5'd11;
        for (int i = 0; i < 3; i++) drive(1, 5'd2, 32'(i), 1, 5'(10 + i), 32'(i + 7));
        rst = 1'b1;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        rst = 1'b0;
        chk("t6_pend1",  32'(bus.pend_hit1), 32'd0);
        chk("t6_ready",  32'(bus.ll_ready),  32'd1);
        for (int i = 0; i < 3; i++) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            bit pwe;
            rst = ($urandom_range(0, 249) == 0);
            pwe = ($urandom_range(0, 2) == 0) && !(mstarve == LIMIT && $urandom_range(0, 1) == 0);
            bus.chk_addr1 = 5'($urandom_range(0, 7));
            bus.chk_addr2 = 5'($urandom_range(0, 7));
            drive(pwe, 5'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("drain_empty", 32'(eq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
